fifo_stream_reader: RTL and testbench

//  Read-side adapter for the synchronous FIFO. Drives the FIFO's r_en and

---
 rtl/fifo_stream_reader_if.sv | 30 +++
 rtl/fifo_stream_reader.sv | 87 ++++++++
 tb/tb_fifo_stream_reader.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Read-side bundle between the sync FIFO, fifo_stream_reader and the
// downstream stream consumer.
interface fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_r_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      input  m_ready,
      output fifo_r_en,
      output m_valid,
      output m_data
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      output m_ready,
      input  fifo_r_en,
      input  m_valid,
      input  m_data
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// FIFO read adapter: 2-entry skid buffer behind the FIFO's 1-cycle read.
// Define STREAM_READER_COUNT_EN to enable the xfer_count counter.
module fifo_stream_reader #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fifo_stream_reader_if.master   bus,
   output logic [COUNT_WIDTH-1:0] xfer_count
);
   logic [1:0]            occ_q, occ_d;
   logic                  infl_q, infl_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;
   logic                  deq;
   logic [2:0]            level;
   logic [1:0]            wr_idx;

   assign bus.m_valid = (occ_q != 2'd0);
   assign bus.m_data  = head_q;
   assign deq         = bus.m_valid & bus.m_ready;

   // Slots committed after this cycle, counting the word in flight.
   assign level = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, deq};
   assign bus.fifo_r_en = rst_n & ~bus.fifo_empty & (level < 3'd2);

   assign wr_idx = occ_q - {1'b0, deq};

   always_comb begin
      occ_d  = occ_q + {1'b0, infl_q} - {1'b0, deq};
      infl_d = bus.fifo_r_en;
      head_d = head_q;
      tail_d = tail_q;
      if (deq) begin
         head_d = tail_q;
      end
      if (infl_q) begin
         unique case (wr_idx)
            2'd0:    head_d = bus.fifo_rdata;
            default: tail_d = bus.fifo_rdata;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q  <= 2'd0;
         infl_q <= 1'b0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         infl_q <= infl_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

`ifdef STREAM_READER_COUNT_EN
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (deq) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign xfer_count = cnt_q;
`else
   assign xfer_count = '0;
`endif

   no_overflow_a : assert property (
      @(posedge clk) disable iff (!rst_n)
      ({1'b0, occ_q} + {2'b0, infl_q}) <= 3'd2
   );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed + random bench for fifo_stream_reader with a queue-based FIFO
// and an in-order word scoreboard.
module tb_fifo_stream_reader;
   localparam int DW = 8;
   localparam int CW = 16;

   logic          clk;
   logic          rst_n;
   logic [CW-1:0] xfer_count;

   fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

   fifo_stream_reader #(
      .DATA_WIDTH (DW),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .xfer_count(xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cmp_n;
   int err_n;
   int cyc;
   int deq_total;
   logic [DW-1:0] fq [$];
   logic [DW-1:0] sb [$];
   int pop_log [$];
   int deq_log [$];
   logic rst_prev;
   logic stall_prev;
   logic [DW-1:0] stall_data;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      cmp_n++;
      assert (got === exp) else begin
         err_n++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [DW-1:0] v);
      fq.push_back(v);
      bus.fifo_empty = 1'b0;
   endtask

   task automatic clr_logs();
      pop_log.delete();
      deq_log.delete();
   endtask

   task automatic tick();
      logic ren_s;
      logic rs;
      @(negedge clk);
      cyc++;
      if (bus.fifo_empty || !rst_n)
         chk("ren_guard", 32'(bus.fifo_r_en), 32'd0);
      if (!rst_prev) begin
         chk("rst_valid", 32'(bus.m_valid), 32'd0);
         chk("rst_data", 32'(bus.m_data), 32'd0);
      end
      if (rst_n) begin
         if (stall_prev && rst_prev) begin
            chk("hold_valid", 32'(bus.m_valid), 32'd1);
            chk("hold_data", 32'(bus.m_data), 32'(stall_data));
         end
         cmp_n++;
         assert (sb.size() <= 2) else begin
            err_n++;
            $error("FAIL occ_infl got=%0d max=2", sb.size());
         end
`ifdef STREAM_READER_COUNT_EN
         chk("xfer_count", 32'(xfer_count), 32'(deq_total[CW-1:0]));
`else
         chk("xfer_count", 32'(xfer_count), 32'd0);
`endif
         if (bus.m_valid && bus.m_ready) begin
            if (sb.size() == 0) begin
               chk("deq_unexpected", 32'd1, 32'd0);
            end else begin
               chk("deq_data", 32'(bus.m_data), 32'(sb.pop_front()));
            end
            deq_total++;
            deq_log.push_back(cyc);
         end
         if (bus.fifo_r_en && fq.size() != 0) begin
            sb.push_back(fq[0]);
            pop_log.push_back(cyc);
         end
         stall_prev = bus.m_valid & ~bus.m_ready;
         stall_data = bus.m_data;
      end else begin
         stall_prev = 1'b0;
      end
      ren_s = bus.fifo_r_en;
      rs    = rst_n;
      @(posedge clk);
      #1;
      if (!rs) begin
         fq.delete();
         sb.delete();
         deq_total = 0;
      end else if (ren_s && fq.size() != 0) begin
         bus.fifo_rdata = fq.pop_front();
      end
      rst_prev = rs;
      bus.fifo_empty = (fq.size() == 0);
   endtask

   initial begin
      cmp_n = 0;
      err_n = 0;
      cyc = 0;
      deq_total = 0;
      rst_prev = 1'b0;
      stall_prev = 1'b0;
      stall_data = '0;
      rst_n = 1'b0;
      bus.fifo_empty = 1'b0;
      bus.fifo_rdata = '0;
      bus.m_ready = 1'b0;

      // reset held with a non-empty FIFO
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("r1_ren", 32'(bus.fifo_r_en), 32'd0);
         chk("r1_valid", 32'(bus.m_valid), 32'd0);
         chk("r1_data", 32'(bus.m_data), 32'd0);
         chk("r1_cnt", 32'(xfer_count), 32'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.fifo_empty = 1'b1;

      // full-rate streaming and pop->valid latency
      clr_logs();
      wr(8'h11); wr(8'h22); wr(8'h33);
      bus.m_ready = 1'b1;
      repeat (8) tick();
      chk("t2_pops", 32'(pop_log.size()), 32'd3);
      chk("t2_deqs", 32'(deq_log.size()), 32'd3);
      if (pop_log.size() == 3 && deq_log.size() == 3) begin
         chk("t2_pop1", 32'(pop_log[1]), 32'(pop_log[0] + 1));
         chk("t2_pop2", 32'(pop_log[2]), 32'(pop_log[0] + 2));
         chk("t2_deq0", 32'(deq_log[0]), 32'(pop_log[0] + 2));
         chk("t2_deq1", 32'(deq_log[1]), 32'(pop_log[0] + 3));
         chk("t2_deq2", 32'(deq_log[2]), 32'(pop_log[0] + 4));
      end

      // stalled consumer: two pops then backpressure
      clr_logs();
      bus.m_ready = 1'b0;
      wr(8'h11); wr(8'h22); wr(8'h33);
      repeat (6) tick();
      chk("t3_pops", 32'(pop_log.size()), 32'd2);
      chk("t3_head", 32'(bus.m_data), 32'h11);
      bus.m_ready = 1'b1;
      repeat (6) tick();
      chk("t3_pops_all", 32'(pop_log.size()), 32'd3);
      chk("t3_deqs", 32'(deq_log.size()), 32'd3);

      // 16 words, toggled then random ready
      clr_logs();
      for (int i = 0; i < 16; i++) wr(8'(i));
      for (int i = 0; i < 300 && deq_log.size() < 16; i++) begin
         bus.m_ready = (i < 16) ? ~i[0] : 1'($urandom_range(1, 0));
         tick();
      end
      bus.m_ready = 1'b1;
      repeat (3) tick();
      chk("t4_deqs", 32'(deq_log.size()), 32'd16);
      chk("t4_sb", 32'(sb.size()), 32'd0);

      // random writes and random ready
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(2, 0) == 0) wr(8'($urandom));
         bus.m_ready = 1'($urandom_range(1, 0));
         tick();
      end
      bus.m_ready = 1'b1;
      repeat (40) tick();
      chk("rnd_fq", 32'(fq.size()), 32'd0);
      chk("rnd_sb", 32'(sb.size()), 32'd0);

      // empty FIFO, then a single word
      clr_logs();
      repeat (4) tick();
      chk("t5_idle", 32'(pop_log.size()), 32'd0);
      wr(8'hA5);
      repeat (5) tick();
      chk("t5_pops", 32'(pop_log.size()), 32'd1);
      chk("t5_deqs", 32'(deq_log.size()), 32'd1);
      if (pop_log.size() == 1 && deq_log.size() == 1)
         chk("t5_lat", 32'(deq_log[0] - pop_log[0]), 32'd2);

      // reset with a full buffer and more data waiting
      bus.m_ready = 1'b0;
      wr(8'h01); wr(8'h02); wr(8'h03); wr(8'h04);
      repeat (4) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_valid", 32'(bus.m_valid), 32'd0);
      clr_logs();
      wr(8'h5A);
      bus.m_ready = 1'b1;
      repeat (5) tick();
      chk("t6_deqs", 32'(deq_log.size()), 32'd1);

      // counter after 5 transfers and after reset
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) wr(8'(8'h80 + i));
      repeat (10) tick();
`ifdef STREAM_READER_COUNT_EN
      chk("cnt5", 32'(xfer_count), 32'd5);
`else
      chk("cnt5", 32'(xfer_count), 32'd0);
`endif
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      chk("cnt_rst", 32'(xfer_count), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end
endmodule
